otter_pipe_regs: RTL
====================

# otter_pipe_regs

Pipeline register bank for the five-stage OTTER core: the consumer of the hazard unit's stall/flush outputs. It holds the PC and the F/D, D/E, E/M and M/W stage registers, and applies stall (hold) and flush (bubble insert) per stage. It tracks a valid bit per stage so bubbles never write state. It feeds rs1/rs2/rd, regWrite and rf_wr_sel per stage back to the hazard unit.

## Interface
- `XLEN`, 32, data/address width
- `CTRL_W`, 16, opaque decoded-control payload width carried D→W
- `RESET_VEC`, 32'h0, PC value after reset
- `NOP_INSTR`, 32'h0000_0013, instruction injected into F/D on flush
- `CLK`  in  1  core clock, all state on rising edge
- `RST_N`  in  1  asynchronous, active-low reset
- `pc_next_F`  in  XLEN  next PC from PC mux
- `instr_F`  in  32  fetched instruction
- `stall_F`, `stall_D`, `flush_D`, `flush_E`  in  1 each  hazard controls
- `ctrl_D`  in  CTRL_W  decoded control; bit 0 = regWrite, bits 2:1 = rf_wr_sel
- `rs1_D`, `rs2_D`, `rd_D`  in  5 each  decoded register indices
- `opA_D`, `opB_D`  in  XLEN each  register-file read data
- `alu_E`, `opB_fwd_E`  in  XLEN each  execute results to capture
- `result_M`  in  XLEN  memory-stage result
- `pc_F`, `pc_D`, `pc_E`  out  XLEN each  stage PCs
- `instr_D`  out  32  decode instruction
- `ctrl_E`, `ctrl_M`, `ctrl_W`  out  CTRL_W each  stage control
- `rs1_E`, `rs2_E`, `rd_E`, `rd_M`, `rd_W`  out  5 each  indices to hazard unit
- `opA_E`, `opB_E`  out  XLEN each  execute operands
- `alu_M`, `wdata_M`, `result_W`  out  XLEN each  downstream data
- `valid_D`, `valid_E`, `valid_M`, `valid_W`  out  1 each  stage holds a real instruction
- `regWrite_M`, `regWrite_W`  out  1 each  ctrl bit 0 AND valid
- `rf_wr_sel_E`  out  2  ctrl_E[2:1]
- `perf_clr`  in  1  synchronous clear of counters (macro only)
- `perf_stall_cnt`, `perf_flush_cnt`, `perf_retire_cnt`  out  32 each  counters (macro only)

## Operation
- PC register: loads `pc_next_F` each cycle unless `stall_F`.
- F/D: `stall_D` holds. `flush_D` loads `NOP_INSTR` and clears valid_D. Flush wins over stall when both are asserted. Otherwise it captures pc_F, instr_F and sets valid_D=1.
- D/E: never stalls. `flush_E` inserts a bubble: ctrl_E=0, rs1_E=rs2_E=rd_E=0, valid_E=0, operands don't-care but held at 0. Otherwise it captures all D-stage fields, with valid_E=valid_D.
- E/M and M/W: advance unconditionally and propagate valid; rd and ctrl are zeroed when the incoming valid is 0.
- regWrite_M/W are gated by valid, so a bubble never forwards or writes.
- The block has no FSM beyond per-stage valid state. A load-use stall is the hazard unit asserting stall_F, stall_D and flush_E together, producing exactly one bubble in E.

## Timing
- Reset (async, RST_N=0): pc_F=RESET_VEC; instr_D=NOP_INSTR; all valids 0; all indices, ctrl and data 0; counters 0. Release is synchronous to the next CLK edge.
- Latency: an instruction in F at cycle n appears in D at n+1, E at n+2, M at n+3 and W at n+4, absent stalls.
- Stall: each stall cycle adds one cycle of F and D residency. A flushed stage shows valid=0 exactly one cycle later.
- Reset asserted mid-stream discards all in-flight instructions immediately, with no partial writes.

## Configuration
- `OTTER_PIPE_PERF_EN` defined: three 32-bit counters are present. The counters are:
  - stall: cycles with stall_F=1
  - flush: cycles with flush_D|flush_E
  - retire: cycles with valid_W=1
- Counters wrap from 0xFFFF_FFFF to 0. `perf_clr` zeroes all three on the next edge, and clear wins over increment.
- Not defined: the counters and `perf_clr` logic are absent, and the counter outputs are tied to 0.

## Test plan
- Reset then free run with instr_F=0x00A00093, pc_next_F=pc_F+4 → pc_F 0,4,8…; valid_W first 1 on the 4th edge after reset release; rd_W=1 with regWrite_W=1.
- Load-use: stall_F=stall_D=flush_E=1 for one cycle → pc_F and instr_D held one cycle; valid_E=0, rd_E=0, rf_wr_sel_E=0 next cycle; instruction resumes in E one cycle later.
- Branch taken: flush_D=flush_E=1 → instr_D=0x00000013, valid_D=0, valid_E=0; two bubbles reach W with regWrite_W=0.
- Simultaneous stall_D=1 and flush_D=1 → flush wins, with instr_D=NOP_INSTR and valid_D=0.
- RST_N pulsed low mid-stream, asynchronously between edges → all valids 0 and pc_F=RESET_VEC before the next edge.
- With `OTTER_PIPE_PERF_EN`: perf_stall_cnt preloaded to 0xFFFF_FFFF, then one stall cycle → 0. perf_clr together with a stall → 0.

Source files
------------

// File: rtl/otter_pipe_regs_if.sv
// otter_pipe_regs_if: bundles the stage-register data path and hazard
// controls between the OTTER core (master) and the pipeline register bank
// (slave). Performance counter signals are always present on the bus; when
// OTTER_PIPE_PERF_EN is undefined the register bank ties the counters to 0.
interface otter_pipe_regs_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CTRL_W = 16
);
  // F-stage inputs
  logic [XLEN-1:0]   pc_next_F;
  logic [31:0]       instr_F;
  // hazard controls
  logic              stall_F;
  logic              stall_D;
  logic              flush_D;
  logic              flush_E;
  // D-stage inputs
  logic [CTRL_W-1:0] ctrl_D;
  logic [4:0]        rs1_D;
  logic [4:0]        rs2_D;
  logic [4:0]        rd_D;
  logic [XLEN-1:0]   opA_D;
  logic [XLEN-1:0]   opB_D;
  // E/M-stage inputs
  logic [XLEN-1:0]   alu_E;
  logic [XLEN-1:0]   opB_fwd_E;
  logic [XLEN-1:0]   result_M;
  // stage outputs
  logic [XLEN-1:0]   pc_F;
  logic [XLEN-1:0]   pc_D;
  logic [XLEN-1:0]   pc_E;
  logic [31:0]       instr_D;
  logic [CTRL_W-1:0] ctrl_E;
  logic [CTRL_W-1:0] ctrl_M;
  logic [CTRL_W-1:0] ctrl_W;
  logic [4:0]        rs1_E;
  logic [4:0]        rs2_E;
  logic [4:0]        rd_E;
  logic [4:0]        rd_M;
  logic [4:0]        rd_W;
  logic [XLEN-1:0]   opA_E;
  logic [XLEN-1:0]   opB_E;
  logic [XLEN-1:0]   alu_M;
  logic [XLEN-1:0]   wdata_M;
  logic [XLEN-1:0]   result_W;
  logic              valid_D;
  logic              valid_E;
  logic              valid_M;
  logic              valid_W;
  logic              regWrite_M;
  logic              regWrite_W;
  logic [1:0]        rf_wr_sel_E;
  // performance counters
  logic              perf_clr;
  logic [31:0]       perf_stall_cnt;
  logic [31:0]       perf_flush_cnt;
  logic [31:0]       perf_retire_cnt;

  modport master (
    output pc_next_F, instr_F, stall_F, stall_D, flush_D, flush_E,
           ctrl_D, rs1_D, rs2_D, rd_D, opA_D, opB_D,
           alu_E, opB_fwd_E, result_M, perf_clr,
    input  pc_F, pc_D, pc_E, instr_D, ctrl_E, ctrl_M, ctrl_W,
           rs1_E, rs2_E, rd_E, rd_M, rd_W, opA_E, opB_E,
           alu_M, wdata_M, result_W, valid_D, valid_E, valid_M, valid_W,
           regWrite_M, regWrite_W, rf_wr_sel_E,
           perf_stall_cnt, perf_flush_cnt, perf_retire_cnt
  );

  modport slave (
    input  pc_next_F, instr_F, stall_F, stall_D, flush_D, flush_E,
           ctrl_D, rs1_D, rs2_D, rd_D, opA_D, opB_D,
           alu_E, opB_fwd_E, result_M, perf_clr,
    output pc_F, pc_D, pc_E, instr_D, ctrl_E, ctrl_M, ctrl_W,
           rs1_E, rs2_E, rd_E, rd_M, rd_W, opA_E, opB_E,
           alu_M, wdata_M, result_W, valid_D, valid_E, valid_M, valid_W,
           regWrite_M, regWrite_W, rf_wr_sel_E,
           perf_stall_cnt, perf_flush_cnt, perf_retire_cnt
  );
endinterface

// File: rtl/otter_pipe_regs.sv
// otter_pipe_regs: PC and F/D, D/E, E/M, M/W stage registers of the OTTER
// five-stage core with per-stage stall/flush and valid tracking.
// Optional feature macro: OTTER_PIPE_PERF_EN (stall/flush/retire counters).
module otter_pipe_regs #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     CTRL_W    = 16,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input logic CLK,
  input logic RST_N,
  otter_pipe_regs_if.slave p
);

  logic [XLEN-1:0]   pc_F_q, pc_F_d;
  logic [XLEN-1:0]   pc_D_q, pc_E_q;
  logic [31:0]       instr_D_q;
  logic              valid_D_q, valid_E_q, valid_M_q, valid_W_q;
  logic [CTRL_W-1:0] ctrl_E_q, ctrl_M_q, ctrl_W_q;
  logic [4:0]        rs1_E_q, rs2_E_q, rd_E_q, rd_M_q, rd_W_q;
  logic [XLEN-1:0]   opA_E_q, opB_E_q;
  logic [XLEN-1:0]   alu_M_q, wdata_M_q, result_W_q;

  assign pc_F_d = p.stall_F ? pc_F_q : p.pc_next_F;

  // PC register: advance unless fetch is stalled
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) pc_F_q <= RESET_VEC;
    else        pc_F_q <= pc_F_d;
  end

  // F/D register: flush has priority over stall
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_D_q    <= '0;
      instr_D_q <= NOP_INSTR;
      valid_D_q <= 1'b0;
    end else if (p.flush_D) begin
      instr_D_q <= NOP_INSTR;
      valid_D_q <= 1'b0;
    end else if (!p.stall_D) begin
      pc_D_q    <= pc_F_q;
      instr_D_q <= p.instr_F;
      valid_D_q <= 1'b1;
    end
  end

  // D/E register: never holds; flush inserts an all-zero bubble
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N || p.flush_E) begin
      pc_E_q    <= '0;
      ctrl_E_q  <= '0;
      rs1_E_q   <= '0;
      rs2_E_q   <= '0;
      rd_E_q    <= '0;
      opA_E_q   <= '0;
      opB_E_q   <= '0;
      valid_E_q <= 1'b0;
    end else begin
      pc_E_q    <= pc_D_q;
      ctrl_E_q  <= p.ctrl_D;
      rs1_E_q   <= p.rs1_D;
      rs2_E_q   <= p.rs2_D;
      rd_E_q    <= p.rd_D;
      opA_E_q   <= p.opA_D;
      opB_E_q   <= p.opB_D;
      valid_E_q <= valid_D_q;
    end
  end

  // E/M and M/W registers: free-running, control/rd zeroed behind bubbles
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      valid_M_q  <= 1'b0;
      ctrl_M_q   <= '0;
      rd_M_q     <= '0;
      alu_M_q    <= '0;
      wdata_M_q  <= '0;
      valid_W_q  <= 1'b0;
      ctrl_W_q   <= '0;
      rd_W_q     <= '0;
      result_W_q <= '0;
    end else begin
      valid_M_q  <= valid_E_q;
      ctrl_M_q   <= valid_E_q ? ctrl_E_q : '0;
      rd_M_q     <= valid_E_q ? rd_E_q : '0;
      alu_M_q    <= p.alu_E;
      wdata_M_q  <= p.opB_fwd_E;
      valid_W_q  <= valid_M_q;
      ctrl_W_q   <= valid_M_q ? ctrl_M_q : '0;
      rd_W_q     <= valid_M_q ? rd_M_q : '0;
      result_W_q <= p.result_M;
    end
  end

  assign p.pc_F        = pc_F_q;
  assign p.pc_D        = pc_D_q;
  assign p.pc_E        = pc_E_q;
  assign p.instr_D     = instr_D_q;
  assign p.ctrl_E      = ctrl_E_q;
  assign p.ctrl_M      = ctrl_M_q;
  assign p.ctrl_W      = ctrl_W_q;
  assign p.rs1_E       = rs1_E_q;
  assign p.rs2_E       = rs2_E_q;
  assign p.rd_E        = rd_E_q;
  assign p.rd_M        = rd_M_q;
  assign p.rd_W        = rd_W_q;
  assign p.opA_E       = opA_E_q;
  assign p.opB_E       = opB_E_q;
  assign p.alu_M       = alu_M_q;
  assign p.wdata_M     = wdata_M_q;
  assign p.result_W    = result_W_q;
  assign p.valid_D     = valid_D_q;
  assign p.valid_E     = valid_E_q;
  assign p.valid_M     = valid_M_q;
  assign p.valid_W     = valid_W_q;
  assign p.regWrite_M  = ctrl_M_q[0] & valid_M_q;
  assign p.regWrite_W  = ctrl_W_q[0] & valid_W_q;
  assign p.rf_wr_sel_E = ctrl_E_q[2:1];

`ifdef OTTER_PIPE_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;

  // Counter next-state: clear wins over increment, natural 32-bit wrap
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    retire_cnt_d = retire_cnt_q;
    if (p.perf_clr) begin
      stall_cnt_d  = '0;
      flush_cnt_d  = '0;
      retire_cnt_d = '0;
    end else begin
      if (p.stall_F)             stall_cnt_d  = stall_cnt_q + 32'd1;
      if (p.flush_D | p.flush_E) flush_cnt_d  = flush_cnt_q + 32'd1;
      if (valid_W_q)             retire_cnt_d = retire_cnt_q + 32'd1;
    end
  end

  // Counter registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign p.perf_stall_cnt  = stall_cnt_q;
  assign p.perf_flush_cnt  = flush_cnt_q;
  assign p.perf_retire_cnt = retire_cnt_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr   = p.perf_clr;
  assign p.perf_stall_cnt  = '0;
  assign p.perf_flush_cnt  = '0;
  assign p.perf_retire_cnt = '0;
`endif

endmodule
